// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the lfsr_gen block.
//   lfsr_mode_t    : feedback form (Fibonacci / Galois)
//   LFSR_MIN_W/MAX : legal state widths
//   lfsr_taps()    : maximal-length tap mask (tap n -> bit n-1), XAPP052 table
//   lfsr_poly()    : Galois lower-order term mask (taps below the top term, plus x^0)
//   lfsr_steps_ok(): true when STEPS is coprime to the sequence period 2^W-1
// No ports (package).
// -----------------------------------------------------------------------------
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_t;

  localparam int LFSR_MIN_W = 2;
  localparam int LFSR_MAX_W = 32;

  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] m;
    case (width)
      2:       m = 32'h0000_0003;
      3:       m = 32'h0000_0006;
      4:       m = 32'h0000_000C;
      5:       m = 32'h0000_0014;
      6:       m = 32'h0000_0030;
      7:       m = 32'h0000_0060;
      8:       m = 32'h0000_00B8;
      9:       m = 32'h0000_0110;
      10:      m = 32'h0000_0240;
      11:      m = 32'h0000_0500;
      12:      m = 32'h0000_0829;
      13:      m = 32'h0000_100D;
      14:      m = 32'h0000_2015;
      15:      m = 32'h0000_6000;
      16:      m = 32'h0000_D008;
      17:      m = 32'h0001_2000;
      18:      m = 32'h0002_0400;
      19:      m = 32'h0004_0023;
      20:      m = 32'h0009_0000;
      21:      m = 32'h0014_0000;
      22:      m = 32'h0030_0000;
      23:      m = 32'h0042_0000;
      24:      m = 32'h00E1_0000;
      25:      m = 32'h0120_0000;
      26:      m = 32'h0200_0023;
      27:      m = 32'h0400_0013;
      28:      m = 32'h0900_0000;
      29:      m = 32'h1400_0000;
      30:      m = 32'h2000_0029;
      31:      m = 32'h4800_0000;
      32:      m = 32'h8020_0003;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  // Drop the x^W term, move each remaining tap n from bit n-1 to bit n,
  // and add the constant term.  For W=8 this yields 8'h71.
  function automatic logic [31:0] lfsr_poly(input int width);
    logic [31:0] t;
    t = lfsr_taps(width) & ~(32'h1 << (width - 1));
    return (t << 1) | 32'h1;
  endfunction

  // Euclid on (2^W-1, steps); bounded loop keeps it a clean constant function.
  function automatic bit lfsr_steps_ok(input int steps, input int width);
    longint unsigned a;
    longint unsigned b;
    longint unsigned t;
    a = (64'd1 << width) - 64'd1;
    b = longint'(steps);
    for (int i = 0; i < 128; i++) begin
      if (b != 0) begin
        t = a % b;
        a = b;
        b = t;
      end
    end
    return (a == 64'd1);
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// -----------------------------------------------------------------------------
// lfsr_step
// Combinational single-bit LFSR shift for a fixed width and feedback form.
//   state_i [DATA-1:0] : current state
//   state_o [DATA-1:0] : state after one shift
// MODE 0 (Fibonacci): feedback = XOR of tapped bits, shifted in at the LSB.
// MODE 1 (Galois)   : shift left, XOR the lower-term mask when the MSB falls out.
// -----------------------------------------------------------------------------
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int DATA = 8,
  parameter int MODE = 0
) (
  input  logic [DATA-1:0] state_i,
  output logic [DATA-1:0] state_o
);

  localparam logic [31:0]     TAPS32 = lfsr_taps(DATA);
  localparam logic [31:0]     POLY32 = lfsr_poly(DATA);
  localparam logic [DATA-1:0] TAPS   = TAPS32[DATA-1:0];
  localparam logic [DATA-1:0] POLY   = POLY32[DATA-1:0];

  if (MODE == int'(LFSR_GAL)) begin : g_gal
    assign state_o = {state_i[DATA-2:0], 1'b0} ^ (state_i[DATA-1] ? POLY : '0);
  end else begin : g_fib
    assign state_o = {state_i[DATA-2:0], ^(state_i & TAPS)};
  end

endmodule

// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen
// Maximal-length LFSR source with seed load, zero-seed fix, valid/ready output
// and a wrap pulse when the sequence lands back on its origin (last seed).
// Parameters: DATA (2..32), MODE (0 Fibonacci / 1 Galois), STEPS (1..DATA
// shifts per accepted advance), SEED (reset state, 0 is replaced by 1).
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   seed_we    in   load seed on the next edge (wins over an advance)
//   seed       in   seed value
//   out_ready  in   consumer takes out; state advances when out_valid
//   out        out  current state register
//   out_valid  out  out is a sequence value
//   wrap       out  one-cycle pulse: advance landed on origin
//   zero_fix   out  one-cycle pulse: an all-zero seed was replaced by 1
//   period_cnt out  accepted advances since load/reset/wrap, saturating
//                   (present only when LFSR_PERIOD_CNT_EN is defined)
// Optional build macro: LFSR_PERIOD_CNT_EN
// -----------------------------------------------------------------------------
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int              DATA  = 8,
  parameter int              MODE  = 0,
  parameter int              STEPS = 1,
  parameter logic [DATA-1:0] SEED  = {{(DATA-1){1'b0}}, 1'b1}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            seed_we,
  input  logic [DATA-1:0] seed,
  input  logic            out_ready,
  output logic [DATA-1:0] out,
  output logic            out_valid,
  output logic            wrap,
  output logic            zero_fix
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [DATA-1:0] period_cnt
`endif
);

  localparam logic [DATA-1:0] ONE           = {{(DATA-1){1'b0}}, 1'b1};
  localparam logic [DATA-1:0] ORIGIN_RST    = (SEED == '0) ? ONE : SEED;
  localparam bit              STEPS_COPRIME = lfsr_steps_ok(STEPS, DATA);

  if (DATA < LFSR_MIN_W || DATA > LFSR_MAX_W) begin : g_bad_data
    $error("lfsr_gen: DATA=%0d outside %0d..%0d", DATA, LFSR_MIN_W, LFSR_MAX_W);
  end
  if (STEPS < 1 || STEPS > DATA) begin : g_bad_steps
    $error("lfsr_gen: STEPS=%0d outside 1..%0d", STEPS, DATA);
  end

  logic [DATA-1:0] state_q, state_d;
  logic [DATA-1:0] origin_q, origin_d;
  logic            valid_q, valid_d;
  logic            wrap_q, wrap_d;
  logic            zfix_q, zfix_d;
  logic [DATA-1:0] seed_fixed;
  logic            advance;

  // chain[k] = state after k single shifts; the whole chain settles in one cycle.
  logic [DATA-1:0] chain [STEPS+1];
  assign chain[0] = state_q;

  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    lfsr_step #(
      .DATA (DATA),
      .MODE (MODE)
    ) u_step (
      .state_i (chain[gi]),
      .state_o (chain[gi+1])
    );
  end

  assign seed_fixed = (seed == '0) ? ONE : seed;
  assign advance    = valid_q & out_ready & ~seed_we;

  always_comb begin
    state_d  = state_q;
    origin_d = origin_q;
    valid_d  = 1'b1;
    wrap_d   = 1'b0;
    zfix_d   = 1'b0;
    if (seed_we) begin
      // A load restarts the sequence: the loaded value becomes the new origin
      // and out_valid drops for one cycle so the consumer sees the restart.
      state_d  = seed_fixed;
      origin_d = seed_fixed;
      zfix_d   = (seed == '0);
      valid_d  = 1'b0;
    end else if (advance) begin
      state_d = chain[STEPS];
      wrap_d  = (chain[STEPS] == origin_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ORIGIN_RST;
      origin_q <= ORIGIN_RST;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      zfix_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      origin_q <= origin_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      zfix_q   <= zfix_d;
    end
  end

`ifdef LFSR_PERIOD_CNT_EN
  logic [DATA-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (seed_we) begin
      cnt_d = '0;
    end else if (advance) begin
      if (wrap_d) begin
        cnt_d = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign period_cnt = cnt_q;
`endif

  // A STEPS value sharing a factor with 2^DATA-1 shortens the period; flag it
  // in simulation rather than spending logic on it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (STEPS_COPRIME)
        else $error("lfsr_gen: STEPS=%0d not coprime to 2^%0d-1", STEPS, DATA);
      assert (state_q != '0)
        else $error("lfsr_gen: state reached all-zero");
    end
  end

  assign out       = state_q;
  assign out_valid = valid_q;
  assign wrap      = wrap_q;
  assign zero_fix  = zfix_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_gen
// Four lfsr_gen instances share clock, reset and stimulus:
//   a: DATA=4 Fibonacci STEPS=1 SEED=1
//   b: DATA=8 Fibonacci STEPS=1 SEED=0 (becomes 1)
//   c: DATA=8 Galois    STEPS=1 SEED=8'hA5
//   d: DATA=4 Fibonacci STEPS=2 SEED=1
// A reference model computes every output per cycle from plain arithmetic;
// literal sequences pin the model. Build with LFSR_PERIOD_CNT_EN to cover
// the counter port.
// -----------------------------------------------------------------------------
module tb_lfsr_gen;

  localparam int NDUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic       seed_we = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       out_ready = 1'b0;
  logic       chk_en = 1'b0;

  logic [3:0] out_a, out_d;
  logic [7:0] out_b, out_c;
  logic [NDUT-1:0] valid_w, wrap_w, zfix_w;
  logic [7:0] dout [NDUT];
  logic [7:0] dcnt [NDUT];

`ifdef LFSR_PERIOD_CNT_EN
  logic [3:0] cnt_a, cnt_d;
  logic [7:0] cnt_b, cnt_c;
  assign dcnt[0] = {4'h0, cnt_a};
  assign dcnt[1] = cnt_b;
  assign dcnt[2] = cnt_c;
  assign dcnt[3] = {4'h0, cnt_d};
`else
  for (genvar gi = 0; gi < NDUT; gi++) begin : g_nocnt
    assign dcnt[gi] = 8'h00;
  end
`endif

  assign dout[0] = {4'h0, out_a};
  assign dout[1] = out_b;
  assign dout[2] = out_c;
  assign dout[3] = {4'h0, out_d};

  lfsr_gen #(.DATA(4), .MODE(0), .STEPS(1), .SEED(4'd1)) dut_a (
    .clk(clk), .reset(reset), .seed_we(seed_we), .seed(seed[3:0]), .out_ready(out_ready),
    .out(out_a), .out_valid(valid_w[0]), .wrap(wrap_w[0]), .zero_fix(zfix_w[0])
`ifdef LFSR_PERIOD_CNT_EN
    , .period_cnt(cnt_a)
`endif
  );

  lfsr_gen #(.DATA(8), .MODE(0), .STEPS(1), .SEED(8'd0)) dut_b (
    .clk(clk), .reset(reset), .seed_we(seed_we), .seed(seed), .out_ready(out_ready),
    .out(out_b), .out_valid(valid_w[1]), .wrap(wrap_w[1]), .zero_fix(zfix_w[1])
`ifdef LFSR_PERIOD_CNT_EN
    , .period_cnt(cnt_b)
`endif
  );

  lfsr_gen #(.DATA(8), .MODE(1), .STEPS(1), .SEED(8'hA5)) dut_c (
    .clk(clk), .reset(reset), .seed_we(seed_we), .seed(seed), .out_ready(out_ready),
    .out(out_c), .out_valid(valid_w[2]), .wrap(wrap_w[2]), .zero_fix(zfix_w[2])
`ifdef LFSR_PERIOD_CNT_EN
    , .period_cnt(cnt_c)
`endif
  );

  lfsr_gen #(.DATA(4), .MODE(0), .STEPS(2), .SEED(4'd1)) dut_d (
    .clk(clk), .reset(reset), .seed_we(seed_we), .seed(seed[3:0]), .out_ready(out_ready),
    .out(out_d), .out_valid(valid_w[3]), .wrap(wrap_w[3]), .zero_fix(zfix_w[3])
`ifdef LFSR_PERIOD_CNT_EN
    , .period_cnt(cnt_d)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned dw(input int k);
    return (k == 1 || k == 2) ? 8 : 4;
  endfunction

  function automatic int unsigned modulus(input int k);
    return 32'd1 << dw(k);
  endfunction

  function automatic int unsigned reset_seed(input int k);
    case (k)
      2:       return 32'hA5;
      default: return 32'd1;   // a and d use 1; b's SEED of 0 is replaced by 1
    endcase
  endfunction

  function automatic int unsigned shift1(input int k, input int unsigned s);
    int unsigned m;
    int unsigned msb;
    int unsigned taps;
    m   = modulus(k);
    msb = s / (m / 2);
    if (k == 2) begin
      return ((s * 2) % m) ^ ((msb != 0) ? 32'h71 : 32'h0);
    end
    taps = (dw(k) == 4) ? 32'h0C : 32'hB8;
    return (s * 2 + ($countones(s & taps) % 2)) % m;
  endfunction

  function automatic int unsigned advance_of(input int k, input int unsigned s);
    int unsigned r;
    r = s;
    for (int i = 0; i < ((k == 3) ? 2 : 1); i++) r = shift1(k, r);
    return r;
  endfunction

  function automatic int unsigned fixed_seed(input int k, input logic [7:0] sd);
    int unsigned v;
    v = int'(sd) % modulus(k);
    return (v == 0) ? 32'd1 : v;
  endfunction

  int unsigned m_state  [NDUT];
  int unsigned m_origin [NDUT];
  int unsigned m_cnt    [NDUT];
  bit          m_valid  [NDUT];
  bit          m_wrap   [NDUT];
  bit          m_zfix   [NDUT];

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < NDUT; k++) begin
      if (reset) begin
        m_state[k]  <= reset_seed(k);
        m_origin[k] <= reset_seed(k);
        m_valid[k]  <= 1'b0;
        m_wrap[k]   <= 1'b0;
        m_zfix[k]   <= 1'b0;
        m_cnt[k]    <= 0;
      end else if (seed_we) begin
        m_state[k]  <= fixed_seed(k, seed);
        m_origin[k] <= fixed_seed(k, seed);
        m_valid[k]  <= 1'b0;
        m_wrap[k]   <= 1'b0;
        m_zfix[k]   <= ((int'(seed) % modulus(k)) == 0);
        m_cnt[k]    <= 0;
      end else begin
        m_valid[k] <= 1'b1;
        m_zfix[k]  <= 1'b0;
        if (m_valid[k] && out_ready) begin
          m_state[k] <= advance_of(k, m_state[k]);
          m_wrap[k]  <= (advance_of(k, m_state[k]) == m_origin[k]);
          m_cnt[k]   <= (advance_of(k, m_state[k]) == m_origin[k]) ? 0 :
                        (m_cnt[k] == modulus(k) - 1) ? m_cnt[k] : m_cnt[k] + 1;
        end else begin
          m_wrap[k] <= 1'b0;
        end
      end
    end
  end

  // One compare process: every output of every instance, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NDUT; k++) begin
        check($sformatf("out[%0d]", k), 32'(dout[k]), m_state[k]);
        check($sformatf("out_valid[%0d]", k), 32'(valid_w[k]), 32'(m_valid[k]));
        check($sformatf("wrap[%0d]", k), 32'(wrap_w[k]), 32'(m_wrap[k]));
        check($sformatf("zero_fix[%0d]", k), 32'(zfix_w[k]), 32'(m_zfix[k]));
`ifdef LFSR_PERIOD_CNT_EN
        check($sformatf("period_cnt[%0d]", k), 32'(dcnt[k]), m_cnt[k]);
`endif
      end
    end
  end

  // Reset asserted between edges: values must change without a clock edge.
  task automatic mid_reset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check({tag, "_out_a"}, 32'(out_a), 32'h1);
    check({tag, "_out_b"}, 32'(out_b), 32'h1);
    check({tag, "_out_c"}, 32'(out_c), 32'hA5);
    check({tag, "_out_d"}, 32'(out_d), 32'h1);
    check({tag, "_valid"}, 32'(valid_w), 32'h0);
    check({tag, "_wrap"}, 32'(wrap_w), 32'h0);
    check({tag, "_zfix"}, 32'(zfix_w), 32'h0);
`ifdef LFSR_PERIOD_CNT_EN
    check({tag, "_cnt_b"}, 32'(dcnt[1]), 32'h0);
    check({tag, "_cnt_c"}, 32'(dcnt[2]), 32'h0);
`endif
    @(negedge clk);
    seed_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] %s: mid-sequence reset applied", tag);
  endtask

  logic [3:0] seq4  [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
  logic [3:0] seq42 [16] = '{4'h1, 4'h4, 4'h3, 4'hD, 4'h5, 4'h7, 4'hE, 4'h8,
                             4'h2, 4'h9, 4'h6, 4'hA, 4'hB, 4'hF, 4'hC, 4'h1};
  int seen_b [256];
  int seen_c [256];

  initial begin
    int wraps_b, wraps_c, once_b, once_c;
    wraps_b = 0; wraps_c = 0; once_b = 0; once_c = 0;
    for (int v = 0; v < 256; v++) begin
      seen_b[v] = 0;
      seen_c[v] = 0;
    end

    // Reset state, checked asynchronously before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_out_a", 32'(out_a), 32'h1);
    check("rst_out_b", 32'(out_b), 32'h1);
    check("rst_out_c", 32'(out_c), 32'hA5);
    check("rst_out_d", 32'(out_d), 32'h1);
    check("rst_valid", 32'(valid_w), 32'h0);
    check("rst_wrap", 32'(wrap_w), 32'h0);
    check("rst_zfix", 32'(zfix_w), 32'h0);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("first_edge_valid", 32'(valid_w), 32'hF);

    // Free-running with out_ready=1: full periods for all instances.
    for (int i = 0; i <= 255; i++) begin
      if (i <= 15) begin
        check($sformatf("seq4[%0d]", i), 32'(out_a), 32'(seq4[i]));
        check($sformatf("seq4s2[%0d]", i), 32'(out_d), 32'(seq42[i]));
        check($sformatf("wrap_a@%0d", i), 32'(wrap_w[0]), 32'(i == 15));
        check($sformatf("wrap_d@%0d", i), 32'(wrap_w[3]), 32'(i == 15));
        $display("[TB] adv %0d: a=%h d=%h b=%h c=%h", i, out_a, out_d, out_b, out_c);
      end
      if (i >= 1) begin
        seen_b[out_b]++;
        seen_c[out_c]++;
        if (wrap_w[1]) wraps_b++;
        if (wrap_w[2]) wraps_c++;
      end
      if (i == 255) begin
        check("wrap_b@255", 32'(wrap_w[1]), 32'h1);
        check("wrap_c@255", 32'(wrap_w[2]), 32'h1);
        check("out_c@255", 32'(out_c), 32'hA5);
      end
      @(negedge clk);
    end
    for (int v = 1; v < 256; v++) begin
      if (seen_b[v] == 1) once_b++;
      if (seen_c[v] == 1) once_c++;
    end
    check("fib8_distinct", 32'(once_b), 32'd255);
    check("gal8_distinct", 32'(once_c), 32'd255);
    check("fib8_zero_seen", 32'(seen_b[0]), 32'd0);
    check("gal8_zero_seen", 32'(seen_c[0]), 32'd0);
    check("fib8_wraps", 32'(wraps_b), 32'd1);
    check("gal8_wraps", 32'(wraps_c), 32'd1);
    $display("[TB] full period: fib8 distinct=%0d wraps=%0d, gal8 distinct=%0d wraps=%0d",
             once_b, wraps_b, once_c, wraps_c);

    // Zero seed with a concurrent out_ready.
    seed_we = 1'b1;
    seed = 8'h00;
    @(negedge clk);
    check("zseed_out_b", 32'(out_b), 32'h1);
    check("zseed_out_c", 32'(out_c), 32'h1);
    check("zseed_zfix", 32'(zfix_w), 32'hF);
    check("zseed_valid", 32'(valid_w), 32'h0);
    seed_we = 1'b0;
    @(negedge clk);
    check("zseed_hold_b", 32'(out_b), 32'h1);
    check("zseed_valid_back", 32'(valid_w), 32'hF);
    check("zseed_zfix_clr", 32'(zfix_w), 32'h0);
    @(negedge clk);
    check("zseed_adv_b", 32'(out_b), 32'h2);
    check("zseed_adv_c", 32'(out_c), 32'h2);
    $display("[TB] zero-seed load: b=%h c=%h", out_b, out_c);

    // Back-to-back loads keep out_valid low.
    seed_we = 1'b1;
    seed = 8'h3C;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("b2b_valid[%0d]", j), 32'(valid_w), 32'h0);
    end
    seed_we = 1'b0;
    @(negedge clk);
    check("b2b_valid_rise", 32'(valid_w), 32'hF);
    check("b2b_out_a", 32'(out_a), 32'hC);
    check("b2b_out_b", 32'(out_b), 32'h3C);
    $display("[TB] back-to-back load: a=%h b=%h", out_a, out_b);

    // In-flight zero_fix pulse is cleared by an asynchronous reset.
    @(negedge clk);
    seed_we = 1'b1;
    seed = 8'h00;
    mid_reset("rst_zfix");

    // Random handshake and loads.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      seed_we   = ($urandom_range(0, 31) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if (i % 500 == 0) begin
        $display("[TB] random %0d: ready=%0b we=%0b seed=%h b=%h c=%h",
                 i, out_ready, seed_we, seed, out_b, out_c);
      end
    end
    @(negedge clk);
    seed_we = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    mid_reset("rst_mid");
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
